// File: rtl/arpas_tx_pkg.sv
// Shared types and constants for the ARPAS 2-bit TDM transmitter.
package arpas_tx_pkg;

    localparam int unsigned ARPAS_SLOTS   = 4;
    localparam int unsigned ARPAS_SLOT_W  = 2;
    localparam int unsigned ARPAS_GAP_CYC = 3;
    localparam int unsigned ARPAS_CNT_W   = 8;

    typedef logic [ARPAS_SLOT_W-1:0] slot_t;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StGap1,
        StStep,
        StGap2
    } tx_state_t;

endpackage

// File: rtl/arpas_slot_timer.sv
// DATA-phase down-counter: load sets DATA_CYC-1, expiry flags the last data cycle.
module arpas_slot_timer
    import arpas_tx_pkg::*;
#(
    parameter int unsigned DATA_CYC = 4
) (
    input  logic i_c,
    input  logic i_r_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expired
);

    logic [ARPAS_CNT_W-1:0] r_cnt;
    logic [ARPAS_CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_load) begin
            w_cnt_d = ARPAS_CNT_W'(DATA_CYC - 1);
        end else if (i_dec && (r_cnt != '0)) begin
            w_cnt_d = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_c or negedge i_r_n) begin
        if (!i_r_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/arpas_tdm_tx.sv
// ARPAS TDM transmitter: serialises four channel bits with inc steps per slot.
// Optional ARPAS_TX_LOOP_EN: repeat frames back-to-back, re-sampling din each frame.
module arpas_tdm_tx
    import arpas_tx_pkg::*;
#(
    parameter int unsigned DATA_CYC = 4
) (
    input  logic                    i_c,
    input  logic                    i_r_n,
    input  logic                    i_start,
    input  logic [ARPAS_SLOTS-1:0]  i_din,
    output logic                    o_ready,
    output logic                    o_sig,
    output logic                    o_inc,
    output logic [ARPAS_SLOT_W-1:0] o_slot,
    output logic                    o_done
);

    tx_state_t              r_state;
    tx_state_t              w_state_d;
    slot_t                  r_slot;
    slot_t                  w_slot_d;
    logic [ARPAS_SLOTS-1:0] r_shadow;
    logic [ARPAS_SLOTS-1:0] w_shadow_d;

    logic r_ready;
    logic r_sig;
    logic r_inc;
    logic r_done;
    logic w_ready_d;
    logic w_sig_d;
    logic w_inc_d;
    logic w_done_d;

    logic w_accept;
    logic w_load;
    logic w_dec;
    logic w_expired;

    assign w_accept = i_start & r_ready;

    arpas_slot_timer #(
        .DATA_CYC (DATA_CYC)
    ) u_timer (
        .i_c       (i_c),
        .i_r_n     (i_r_n),
        .i_load    (w_load),
        .i_dec     (w_dec),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_d  = r_state;
        w_slot_d   = r_slot;
        w_shadow_d = r_shadow;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d  = StData;
                    w_slot_d   = '0;
                    w_shadow_d = i_din;
                    w_load     = 1'b1;
                end
            end
            StData: begin
                if (w_expired) begin
                    w_state_d = StGap1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            StGap1: w_state_d = StStep;
            StStep: w_state_d = StGap2;
            StGap2: begin
                if (r_slot != slot_t'(ARPAS_SLOTS - 1)) begin
                    w_state_d = StData;
                    w_slot_d  = r_slot + 1'b1;
                    w_load    = 1'b1;
                end else begin
`ifdef ARPAS_TX_LOOP_EN
                    w_state_d  = StData;
                    w_slot_d   = '0;
                    w_shadow_d = i_din;
                    w_load     = 1'b1;
`else
                    w_state_d = StIdle;
                    w_slot_d  = '0;
`endif
                end
            end
            default: begin
                w_state_d = StIdle;
                w_slot_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet cycle-aligned
    always_comb begin
        w_ready_d = (w_state_d == StIdle);
        w_sig_d   = (w_state_d == StData) & w_shadow_d[w_slot_d];
        w_inc_d   = (w_state_d == StStep);
        w_done_d  = (w_state_d == StGap2) && (w_slot_d == slot_t'(ARPAS_SLOTS - 1));
    end

    always_ff @(posedge i_c or negedge i_r_n) begin
        if (!i_r_n) begin
            r_state  <= StIdle;
            r_slot   <= '0;
            r_shadow <= '0;
            r_ready  <= 1'b0;
            r_sig    <= 1'b0;
            r_inc    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_slot   <= w_slot_d;
            r_shadow <= w_shadow_d;
            r_ready  <= w_ready_d;
            r_sig    <= w_sig_d;
            r_inc    <= w_inc_d;
            r_done   <= w_done_d;
        end
    end

    assign o_ready = r_ready;
    assign o_sig   = r_sig;
    assign o_inc   = r_inc;
    assign o_slot  = r_slot;
    assign o_done  = r_done;

endmodule

// File: tb/tb_arpas_tdm_tx.sv
// Bench for arpas_tdm_tx: frame-position model plus directed hand-computed checks.
module tb_arpas_tdm_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start1;
    logic [3:0] din4, din1;
    logic       ready4, sig4, inc4, done4;
    logic       ready1, sig1, inc1, done1;
    logic [1:0] slot4, slot1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arpas_tdm_tx #(.DATA_CYC(4)) u_d4 (
        .i_c(clk), .i_r_n(rst_n), .i_start(start4), .i_din(din4),
        .o_ready(ready4), .o_sig(sig4), .o_inc(inc4), .o_slot(slot4), .o_done(done4)
    );

    arpas_tdm_tx #(.DATA_CYC(1)) u_d1 (
        .i_c(clk), .i_r_n(rst_n), .i_start(start1), .i_din(din1),
        .o_ready(ready1), .o_sig(sig1), .o_inc(inc1), .o_slot(slot1), .o_done(done1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is 4 slots of D+3 cycles; pos counts cycles since acceptance (0 = idle)
    int unsigned dcyc[2] = '{4, 1};
    int          pos[2];
    logic [3:0]  sh[2];
    bit          rdy[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pos[i] = 0;
                rdy[i] = 1'b0;
                sh[i]  = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int flen;
                logic st;
                logic [3:0] dn;
                flen = 4 * (int'(dcyc[i]) + 3);
                st   = (i == 0) ? start4 : start1;
                dn   = (i == 0) ? din4 : din1;
                if (pos[i] == 0 && rdy[i] && st) begin
                    pos[i] = 1;
                    sh[i]  = dn;
                end else if (pos[i] == flen) begin
                    pos[i] = 0;
                end else if (pos[i] > 0) begin
                    pos[i] = pos[i] + 1;
                end
                rdy[i] = (pos[i] == 0);
            end
        end
    end

    // Returns {ready, done, slot[1:0], inc, sig}
    function automatic logic [5:0] model_out(input int i);
        int d, len, k, q;
        logic s, n, dn;
        logic [1:0] sl;
        d   = int'(dcyc[i]);
        len = d + 3;
        s = 1'b0; n = 1'b0; dn = 1'b0; sl = 2'd0;
        if (pos[i] > 0) begin
            k  = (pos[i] - 1) / len;
            q  = (pos[i] - 1) % len;
            sl = 2'(k);
            s  = (q < d) && sh[i][k];
            n  = (q == d + 1);
            dn = (pos[i] == 4 * len);
        end
        return {rdy[i], dn, sl, n, s};
    endfunction

    always @(negedge clk) begin
        logic [5:0] e4, e1;
        e4 = model_out(0);
        e1 = model_out(1);
        chk("d4_outputs", {58'd0, ready4, done4, slot4, inc4, sig4}, {58'd0, e4});
        chk("d1_outputs", {58'd0, ready1, done1, slot1, inc1, sig1}, {58'd0, e1});
        chk("d4_sig_inc_excl", {63'd0, sig4 & inc4}, 64'd0);
    end

    initial begin
        logic [63:0] v_sig, v_inc, v_done, v_rdy;
        logic [3:0]  seen;
        int          rx, incs;

        rst_n = 1'b0;
        start4 = 1'b0; start1 = 1'b0;
        din4 = '0; din1 = '0;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_outs_d4", {59'd0, ready4, sig4, inc4, slot4, done4}, 64'd0);
        chk("rst_outs_d1", {59'd0, ready1, sig1, inc1, slot1, done1}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {62'd0, ready4, ready1}, 64'd3);

        // Single frame, din=1010, with a receiver model
        start4 = 1'b1; din4 = 4'b1010;
        @(posedge clk);
        v_sig = '0; v_inc = '0; v_done = '0; v_rdy = '0; seen = '0; rx = 0;
        for (int n = 1; n <= 29; n++) begin
            @(negedge clk);
            if (n == 1) start4 = 1'b0;
            v_sig[n] = sig4; v_inc[n] = inc4; v_done[n] = done4; v_rdy[n] = ready4;
            if (sig4) seen[rx % 4] = 1'b1;
            if (inc4) rx++;
        end
        chk("frame_sig", v_sig, 64'h03C0_0F00);
        chk("frame_inc", v_inc, 64'h0810_2040);
        chk("frame_done", v_done, 64'h1000_0000);
        chk("frame_ready", v_rdy, 64'h2000_0000);
        chk("rx_outputs_seen", {60'd0, seen}, 64'hA);
        chk("rx_inc_count", 64'(rx), 64'd4);

        // Snapshot: din changed after acceptance must not matter
        start4 = 1'b1; din4 = 4'hF;
        @(posedge clk);
        v_sig = '0;
        for (int n = 1; n <= 29; n++) begin
            @(negedge clk);
            if (n == 1) start4 = 1'b0;
            if (n == 2) din4 = 4'h0;
            v_sig[n] = sig4;
        end
        chk("snapshot_sig", v_sig, 64'h03C7_8F1E);

        // Back-to-back with start held, DATA_CYC=1
        start1 = 1'b1; din1 = 4'h5;
        @(posedge clk);
        v_inc = '0; v_done = '0; v_rdy = '0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            v_inc[n] = inc1; v_done[n] = done1; v_rdy[n] = ready1;
        end
        start1 = 1'b0;
        chk("b2b_ready", v_rdy, 64'h0000_0004_0002_0000);
        chk("b2b_inc", v_inc, 64'h0000_2221_1110_8888);
        chk("b2b_done", v_done, 64'h0000_0002_0001_0000);
        repeat (20) @(negedge clk);
        chk("b2b_idle_ready", {63'd0, ready1}, 64'd1);

        // Mid-frame reset during slot 1 DATA
        start4 = 1'b1; din4 = 4'b1010;
        @(posedge clk);
        incs = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start4 = 1'b0;
            if (inc4) incs++;
        end
        chk("midrst_sig_before", {63'd0, sig4}, 64'd1);
        chk("midrst_incs_sent", 64'(incs), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_async_outs", {59'd0, ready4, sig4, inc4, slot4, done4}, 64'd0);
        @(negedge clk);
        chk("midrst_ready_low", {63'd0, ready4}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", {63'd0, ready4}, 64'd1);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
